img_mem_streamer: RTL and testbench

Parametrised image-memory read engine for the interpolation datapath. It scans a synchronous-read image memory (ROM or one RAM port) over a programmable address range and streams the words out on a valid/ready interface. An internal credit-managed FIFO absorbs backpressure without losing in-flight reads. It replaces ad-hoc sequential address sweeps as the standard pixel source feeding the interpolation units.

---
 rtl/img_mem_streamer_if.sv | 31 +++
 rtl/img_mem_streamer.sv | 170 +++++++++++++++++
 tb/tb_img_mem_streamer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/img_mem_streamer_if.sv
// ============================================================================
// Module   : img_mem_streamer_if
// Purpose  : Memory read port and pixel stream bundle for img_mem_streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface img_mem_streamer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_addr, mem_rd_en, out_data, out_valid, out_last,
    input  mem_q, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, out_data, out_valid, out_last,
    output mem_q, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/img_mem_streamer.sv
// ============================================================================
// Module   : img_mem_streamer
// Purpose  : Scans a synchronous-read image memory and streams words through a
//            credit-managed FIFO. IMG_WINDOW_EN adds 2D window addressing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_mem_streamer #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
`ifdef IMG_WINDOW_EN
  input  logic [ADDR_W-1:0] win_cols_i,
  input  logic [ADDR_W-1:0] win_stride_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  img_mem_streamer_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    rd_rem_q, rd_rem_d;
  logic               infl_q, infl_last_q;
  logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PW-1:0]      wptr_q, rptr_q;
  logic [PW:0]        fcnt_q;
`ifdef IMG_WINDOW_EN
  logic [ADDR_W-1:0]  row_q, row_d, col_q, col_d, cols_q, cols_d, stride_q, stride_d;
`endif

  logic          push, pop, rd_en, last_rd, credit_ok, head_last;
  logic [PW+1:0] occ;

  assign push      = infl_q;
  assign pop       = bus.out_valid && bus.out_ready;
  assign last_rd   = (rd_rem_q == (ADDR_W+1)'(1));
  assign head_last = fifo_last_q[rptr_q];

  // A read is allowed only if its word is guaranteed a FIFO slot on arrival.
  assign occ       = {1'b0, fcnt_q} + {{(PW+1){1'b0}}, infl_q} - {{(PW+1){1'b0}}, pop};
  assign credit_ok = occ < (PW+2)'(FIFO_DEPTH);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_rem_d = rd_rem_q;
    rd_en    = 1'b0;
`ifdef IMG_WINDOW_EN
    row_d    = row_q;
    col_d    = col_q;
    cols_d   = cols_q;
    stride_d = stride_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          rd_rem_d = count_i;
          state_d  = (count_i == '0) ? S_DONE : S_RUN;
`ifdef IMG_WINDOW_EN
          row_d    = base_addr_i;
          col_d    = '0;
          cols_d   = (win_cols_i == '0) ? ADDR_W'(1) : win_cols_i;
          stride_d = win_stride_i;
`endif
        end
      end
      S_RUN: begin
        rd_en = (rd_rem_q != '0) && credit_ok;
        if (rd_en) begin
          rd_rem_d = rd_rem_q - (ADDR_W+1)'(1);
`ifdef IMG_WINDOW_EN
          if (col_q == cols_q - ADDR_W'(1)) begin
            addr_d = row_q + stride_q;
            row_d  = row_q + stride_q;
            col_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            col_d  = col_q + ADDR_W'(1);
          end
`else
          addr_d = addr_q + ADDR_W'(1);
`endif
          if (last_rd) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rd_rem_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      fifo_last_q <= '0;
`ifdef IMG_WINDOW_EN
      row_q       <= '0;
      col_q       <= '0;
      cols_q      <= '0;
      stride_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_rem_q    <= rd_rem_d;
      infl_q      <= rd_en;
      infl_last_q <= rd_en && last_rd;
`ifdef IMG_WINDOW_EN
      row_q       <= row_d;
      col_q       <= col_d;
      cols_q      <= cols_d;
      stride_q    <= stride_d;
`endif
      if (push) begin
        wptr_q              <= wptr_q + 1'b1;
        fifo_last_q[wptr_q] <= infl_last_q;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // Storage needs no reset: reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) fifo_data_q[wptr_q] <= bus.mem_q;
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd_en = rd_en;
  assign bus.out_valid = (fcnt_q != '0);
  assign bus.out_data  = bus.out_valid ? fifo_data_q[rptr_q] : '0;
  assign bus.out_last  = bus.out_valid && head_last;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_img_mem_streamer.sv
// ============================================================================
// Module   : tb_img_mem_streamer
// Purpose  : Directed self-checking bench for img_mem_streamer (ROM mem[a]=a[7:0]).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_mem_streamer;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic              busy, done;
`ifdef IMG_WINDOW_EN
  logic [ADDR_W-1:0] win_cols, win_stride;
  int                win_on = 0, win_c = 1, win_s = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  img_mem_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  img_mem_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base),
    .count_i     (count),
`ifdef IMG_WINDOW_EN
    .win_cols_i  (win_cols),
    .win_stride_i(win_stride),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_q <= bus.mem_addr[7:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] b, input int k);
`ifdef IMG_WINDOW_EN
    if (win_on != 0) return b + ADDR_W'((k / win_c) * win_s + (k % win_c));
`endif
    return b + ADDR_W'(k);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
    check({tag, "_addr"},  32'(bus.mem_addr), 0);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_last"},  32'(bus.out_last), 0);
    check({tag, "_data"},  32'(bus.out_data), 0);
  endtask

  // One scan; cycle index 1 is the cycle after the start edge.
  task automatic run_scan(input logic [ADDR_W-1:0] b, input int cnt, input int ready_pct,
                          input bit poke, input int abort_at);
    int issued = 0, beats = 0, done_n = 0, done_cyc = -1, first_v = -1, last_cyc = -1;
    int budget = cnt * 20 + 50;
    bit finished = 0, stall_prev = 0, rd;
    logic [DATA_W-1:0] data_prev = '0;
    logic [ADDR_W-1:0] ea;

    @(negedge clk);
    start = 1'b1;
    base  = b;
    count = (ADDR_W+1)'(cnt);
    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      @(negedge clk);
      start = poke && (cyc == 4 || cyc == 10);
      if (start) begin
        base  = 15'h0055;
        count = 16'd2;
      end
      bus.out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (stall_prev) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_data",  32'(bus.out_data), 32'(data_prev));
      end
      rd = bus.mem_rd_en;
      if (rd) begin
        check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr(b, issued)));
        issued++;
      end
      if (bus.out_valid && first_v < 0) first_v = cyc;
      if (bus.out_valid && bus.out_ready) begin
        ea = exp_addr(b, beats);
        check("out_data", 32'(bus.out_data), 32'(ea[7:0]));
        check("out_last", 32'(bus.out_last), 32'(beats == cnt - 1));
        beats++;
        last_cyc = cyc;
      end
      if (rd) check("credit", 32'((issued - beats) <= FIFO_DEPTH), 1);
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      if (abort_at > 0 && beats == abort_at) begin
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #1;
          check("abort_no_done",  32'(done), 0);
          check("abort_no_valid", 32'(bus.out_valid), 0);
        end
        return;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        check("busy_after_done", 32'(busy), 0);
        finished = 1;
      end
    end
    start = 1'b0;
    if (!finished) check("timeout", 0, 1);
    check("beats",  32'(beats), 32'(cnt));
    check("reads",  32'(issued), 32'(cnt));
    check("done_n", 32'(done_n), 1);
    check("done_cyc", 32'(done_cyc), (cnt == 0) ? 32'd1 : 32'(last_cyc + 1));
    if (ready_pct >= 100) begin
      check("first_valid", 32'(first_v), (cnt == 0) ? 32'hFFFF_FFFF : 32'd3);
      if (cnt > 0) check("last_beat_cyc", 32'(last_cyc), 32'(cnt + 2));
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b1;
    base          = 15'h1111;
    count         = 16'd5;
    bus.out_ready = 1'b0;
`ifdef IMG_WINDOW_EN
    win_cols      = '0;
    win_stride    = '0;
`endif
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    #1;
    check("reset_start_ignored", 32'(busy), 0);

    run_scan(15'h0100, 16, 100, 0, 0);   // linear, full rate
    run_scan(15'h0200, 64, 30, 0, 0);    // backpressure
    run_scan(15'h0000, 0, 100, 0, 0);    // empty scan
    run_scan(15'h7FFE, 4, 100, 0, 0);    // address wrap
    run_scan(15'h0300, 32, 100, 0, 5);   // reset mid-scan
    run_scan(15'h0040, 4, 100, 0, 0);    // fresh scan after reset
    run_scan(15'h0100, 16, 100, 1, 0);   // start pulses while busy
    run_scan(15'h1234, 1 << ADDR_W, 100, 0, 0); // whole memory
`ifdef IMG_WINDOW_EN
    win_on     = 1;
    win_c      = 3;
    win_s      = 160;
    win_cols   = 15'd3;
    win_stride = 15'd160;
    run_scan(15'h0000, 7, 100, 0, 0);
    run_scan(15'h0000, 7, 40, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
